product_accumulator: RTL

- Downstream consumer of the generic m x n array multiplier; receives a stream of unsigned products, one per beat, over a valid/ready handshake.
- Sums the products of a packet (terminated by `prod_last`) into a wide accumulator.
- Presents the packet sum, the beat count and an overflow flag on an output handshake.
- Turns the combinational multiplier into a dot-product / MAC back-end.

---
 rtl/acc_pkg.sv | 18 +
 rtl/acc_add_sat.sv | 24 ++
 rtl/product_accumulator.sv | 131 +++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared state type, default widths and accumulator width helper
package acc_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    localparam int PW_DEFAULT    = 128;
    localparam int GUARD_DEFAULT = 8;
    localparam int LEN_W_DEFAULT = 16;

    // Accumulator width: product width plus guard bits against growth over a packet
    function automatic int acc_width(input int pw, input int guard);
        return pw + guard;
    endfunction

endpackage

// File: rtl/acc_add_sat.sv
// rtl/acc_add_sat.sv - AW-bit adder with carry out; clamps to all-ones when ACC_SATURATE_EN is defined
module acc_add_sat #(
    parameter int AW = 136
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    output logic [AW-1:0] sum,
    output logic          carry
);

    logic [AW:0] full;

    // One extra bit catches the carry; the clamp keeps a saturated sum pinned at all-ones
    always_comb begin
        full  = {1'b0, a} + {1'b0, b};
        carry = full[AW];
`ifdef ACC_SATURATE_EN
        sum   = full[AW] ? {AW{1'b1}} : full[AW-1:0];
`else
        sum   = full[AW-1:0];
`endif
    end

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums packets of multiplier products; saturating sum under ACC_SATURATE_EN
module product_accumulator
    import acc_pkg::*;
#(
    parameter  int PW    = PW_DEFAULT,
    parameter  int GUARD = GUARD_DEFAULT,
    parameter  int LEN_W = LEN_W_DEFAULT,
    localparam int AW    = acc_width(PW, GUARD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [PW-1:0]    product,
    input  logic             prod_last,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [AW-1:0]    acc_out,
    output logic [LEN_W-1:0] acc_count,
    output logic             overflow
);

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

    acc_state_t       state;
    acc_state_t       state_next;
    logic [AW-1:0]    acc;
    logic [LEN_W-1:0] count;
    logic             ovf;

    logic [AW-1:0]    prod_ext;
    logic [AW-1:0]    add_sum;
    logic             add_carry;
    logic [LEN_W-1:0] count_inc;

    logic             load_add;
    logic             load_new;
    logic             clear;

    assign prod_ext  = AW'(product);
    assign count_inc = count + CNT_ONE;

    acc_add_sat #(
        .AW(AW)
    ) u_add (
        .a    (acc),
        .b    (prod_ext),
        .sum  (add_sum),
        .carry(add_carry)
    );

    // Next state, handshakes and register-update selects
    always_comb begin
        state_next = state;
        prod_ready = 1'b0;
        acc_valid  = 1'b0;
        load_add   = 1'b0;
        load_new   = 1'b0;
        clear      = 1'b0;
        case (state)
            ACCUM: begin
                prod_ready = 1'b1;
                if (prod_valid) begin
                    load_add = 1'b1;
                    // Forced end at a full counter so the beat count never wraps
                    if (prod_last || (count_inc == CNT_MAX)) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                acc_valid  = 1'b1;
                prod_ready = acc_ready;
                if (acc_ready) begin
                    if (prod_valid) begin
                        // Result leaves while the first beat of the next packet arrives
                        load_new = 1'b1;
                        if (!(prod_last || (CNT_ONE == CNT_MAX))) begin
                            state_next = ACCUM;
                        end
                    end else begin
                        clear      = 1'b1;
                        state_next = ACCUM;
                    end
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // State, running sum, beat count and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            if (load_add) begin
                acc   <= add_sum;
                count <= count_inc;
                ovf   <= ovf | add_carry;
            end else if (load_new) begin
                acc   <= prod_ext;
                count <= CNT_ONE;
                ovf   <= 1'b0;
            end else if (clear) begin
                acc   <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end
        end
    end

    // Result fields read as zero until a packet is complete
    always_comb begin
        acc_out   = '0;
        acc_count = '0;
        overflow  = 1'b0;
        if (state == HOLD) begin
            acc_out   = acc;
            acc_count = count;
            overflow  = ovf;
        end
    end

endmodule
